vec_bank_lsu: RTL and testbench

//  Vector load/store unit for the vector pipeline. Moves one VLEN-element vector between a vector

---
 rtl/vec_bank_lsu.sv | 208 ++++++++++++++++++++
 tb/tb_vec_bank_lsu.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/vec_bank_lsu.sv
// Vector load/store unit: moves one VLEN-element vector between a vector register and
// NUM_BANKS word-interleaved memory banks, one element per bank per beat.
module vec_bank_lsu #(
    parameter int ELEM_W    = 16,
    parameter int VLEN      = 16,
    parameter int NUM_BANKS = 4,
    parameter int ADDR_W    = 16,
    parameter int BANK_AW   = ADDR_W - 1 - $clog2(NUM_BANKS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_store,
    input  logic [ADDR_W-1:0]             req_base,
    input  logic [3:0]                    req_vreg,
    input  logic [VLEN*ELEM_W-1:0]        req_wdata,
    output logic [NUM_BANKS-1:0]          bank_ren,
    output logic [NUM_BANKS*BANK_AW-1:0]  bank_raddr,
    input  logic [NUM_BANKS*ELEM_W-1:0]   bank_rdata,
    output logic [NUM_BANKS-1:0]          bank_wen,
    output logic [NUM_BANKS*BANK_AW-1:0]  bank_waddr,
    output logic [NUM_BANKS*ELEM_W-1:0]   bank_wdata,
    output logic                          wb_valid,
    output logic [3:0]                    wb_vreg,
    output logic [VLEN*ELEM_W-1:0]        wb_data,
    output logic                          busy
);
    localparam int WORD_AW = ADDR_W - 1;
    localparam int LOG_NB  = $clog2(NUM_BANKS);
    localparam int NBEAT   = VLEN / NUM_BANKS;
    localparam int BEAT_W  = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam int ELEM_IW = $clog2(VLEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WB    = 3'd3,
        ST_STORE = 3'd4
    } state_t;

    state_t                       state_r, state_next_s;
    logic [BEAT_W-1:0]            beat_r, beat_next_s, cap_beat_s;
    logic [WORD_AW-1:0]           base_w_r;
    logic [3:0]                   vreg_r, wb_vreg_r;
    logic [VLEN*ELEM_W-1:0]       wdata_r, cap_r, cap_next_s, wb_data_r;
    logic                         accept_s, ren_s, wen_s, cap_en_s, wb_load_s;
    logic [LOG_NB-1:0]            bank_off_s   [NUM_BANKS];
    logic [ELEM_IW-1:0]           issue_elem_s [NUM_BANKS];
    logic [ELEM_IW-1:0]           cap_elem_s   [NUM_BANKS];
    logic [NUM_BANKS*BANK_AW-1:0] beat_idx_s;
    logic [NUM_BANKS*ELEM_W-1:0]  beat_wdata_s;
    logic                         unused_base_s;

    // Element slot served by a bank in a given beat (offset is below NUM_BANKS, so OR is a sum).
    function automatic logic [ELEM_IW-1:0] elem_idx(input logic [BEAT_W-1:0] beat,
                                                    input logic [LOG_NB-1:0] off);
        return (ELEM_IW'(beat) << LOG_NB) | ELEM_IW'(off);
    endfunction

    // Bank-local word index; the word address wraps modulo 2^WORD_AW.
    function automatic logic [BANK_AW-1:0] bank_index(input logic [WORD_AW-1:0] base_w,
                                                      input logic [BEAT_W-1:0]  beat,
                                                      input logic [LOG_NB-1:0]  off);
        logic [WORD_AW-1:0] word;
        word = base_w + (WORD_AW'(beat) << LOG_NB) + WORD_AW'(off);
        return word[WORD_AW-1:LOG_NB];
    endfunction

    assign unused_base_s = req_base[0];
    assign req_ready     = rst_n & (state_r == ST_IDLE) & ~flush;
    assign accept_s      = req_valid & req_ready;
    assign ren_s         = (state_r == ST_LOAD) & ~flush;
    assign wen_s         = (state_r == ST_STORE) & ~flush;
    assign wb_load_s     = (state_r == ST_DRAIN) & ~flush;

    assign bank_ren   = {NUM_BANKS{ren_s}};
    assign bank_raddr = ren_s ? beat_idx_s : '0;
    assign bank_wen   = {NUM_BANKS{wen_s}};
    assign bank_waddr = wen_s ? beat_idx_s : '0;
    assign bank_wdata = wen_s ? beat_wdata_s : '0;
    assign wb_valid   = (state_r == ST_WB) & ~flush;
    assign wb_vreg    = wb_vreg_r;
    assign wb_data    = wb_data_r;
    assign busy       = (state_r != ST_IDLE);

    // Capture qualifier: read data returned this cycle belongs to the previous issue beat.
    always_comb begin
        cap_en_s   = 1'b0;
        cap_beat_s = LAST_BEAT;
        if (state_r == ST_DRAIN) begin
            cap_en_s   = 1'b1;
            cap_beat_s = LAST_BEAT;
        end else if ((state_r == ST_LOAD) && (beat_r != BEAT_W'(0))) begin
            cap_en_s   = 1'b1;
            cap_beat_s = beat_r - BEAT_W'(1);
        end else begin
            cap_en_s   = 1'b0;
            cap_beat_s = LAST_BEAT;
        end
    end

    // Per-bank element mapping, word index and write data for the current beat.
    always_comb begin
        beat_idx_s   = '0;
        beat_wdata_s = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            bank_off_s[k]   = LOG_NB'(k) - base_w_r[LOG_NB-1:0];
            issue_elem_s[k] = elem_idx(beat_r, bank_off_s[k]);
            cap_elem_s[k]   = elem_idx(cap_beat_s, bank_off_s[k]);
            beat_idx_s[k*BANK_AW +: BANK_AW] = bank_index(base_w_r, beat_r, bank_off_s[k]);
            beat_wdata_s[k*ELEM_W +: ELEM_W] = wdata_r[issue_elem_s[k]*ELEM_W +: ELEM_W];
        end
    end

    // Merge returned bank data into the capture buffer slots (rotation undone by cap_elem_s).
    always_comb begin
        cap_next_s = cap_r;
        if (cap_en_s) begin
            for (int k = 0; k < NUM_BANKS; k++) begin
                cap_next_s[cap_elem_s[k]*ELEM_W +: ELEM_W] = bank_rdata[k*ELEM_W +: ELEM_W];
            end
        end else begin
            cap_next_s = cap_r;
        end
    end

    // Next-state and beat counter.
    always_comb begin
        state_next_s = state_r;
        beat_next_s  = beat_r;
        case (state_r)
            ST_IDLE: begin
                beat_next_s = BEAT_W'(0);
                if (accept_s) begin
                    state_next_s = req_store ? ST_STORE : ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (flush) begin
                    state_next_s = ST_IDLE;
                    beat_next_s  = BEAT_W'(0);
                end else if (beat_r == LAST_BEAT) begin
                    state_next_s = ST_DRAIN;
                    beat_next_s  = BEAT_W'(0);
                end else begin
                    beat_next_s  = beat_r + BEAT_W'(1);
                end
            end
            ST_DRAIN: begin
                beat_next_s = BEAT_W'(0);
                if (flush) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WB;
                end
            end
            ST_WB: begin
                state_next_s = ST_IDLE;
                beat_next_s  = BEAT_W'(0);
            end
            ST_STORE: begin
                if (flush || (beat_r == LAST_BEAT)) begin
                    state_next_s = ST_IDLE;
                    beat_next_s  = BEAT_W'(0);
                end else begin
                    beat_next_s  = beat_r + BEAT_W'(1);
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                beat_next_s  = BEAT_W'(0);
            end
        endcase
    end

    // State, request latch, capture buffer and write-back registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            beat_r    <= '0;
            base_w_r  <= '0;
            vreg_r    <= 4'd0;
            wdata_r   <= '0;
            cap_r     <= '0;
            wb_data_r <= '0;
            wb_vreg_r <= 4'd0;
        end else begin
            state_r <= state_next_s;
            beat_r  <= beat_next_s;
            cap_r   <= cap_next_s;
            if (accept_s) begin
                base_w_r <= req_base[ADDR_W-1:1];
                vreg_r   <= req_vreg;
                wdata_r  <= req_wdata;
            end
            if (wb_load_s) begin
                wb_data_r <= cap_next_s;
                wb_vreg_r <= vreg_r;
            end
        end
    end
endmodule

// File: tb/tb_vec_bank_lsu.sv
// Directed bench for vec_bank_lsu: table of load vectors against a banked memory model,
// plus hand-written store, flush and mid-operation reset sequences.
module tb_vec_bank_lsu;
    logic         clk, rst_n, flush, req_valid, req_ready, req_store;
    logic [15:0]  req_base;
    logic [3:0]   req_vreg, wb_vreg;
    logic [255:0] req_wdata, wb_data;
    logic [3:0]   bank_ren, bank_wen;
    logic [51:0]  bank_raddr, bank_waddr;
    logic [63:0]  bank_rdata, bank_wdata;
    logic         wb_valid, busy, mem_init;

    logic [15:0]  mem [4][8192];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           wb_cnt  = 0;
    int           wb0;

    typedef struct {
        logic [15:0] base;
        logic [3:0]  vreg;
        logic [15:0] e0;
        logic [51:0] raddr0;
    } load_vec_t;
    load_vec_t tbl [5];

    vec_bank_lsu dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_base(req_base), .req_vreg(req_vreg), .req_wdata(req_wdata),
        .bank_ren(bank_ren), .bank_raddr(bank_raddr), .bank_rdata(bank_rdata),
        .bank_wen(bank_wen), .bank_waddr(bank_waddr), .bank_wdata(bank_wdata),
        .wb_valid(wb_valid), .wb_vreg(wb_vreg), .wb_data(wb_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Banked memory: one-cycle read latency, writes on posedge; word w preloaded with w.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < 4; k++)
                for (int j = 0; j < 8192; j++)
                    mem[k][j] <= 16'(j * 4 + k);
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (bank_ren[k]) bank_rdata[k*16 +: 16] <= mem[k][bank_raddr[k*13 +: 13]];
                if (bank_wen[k]) mem[k][bank_waddr[k*13 +: 13]] <= bank_wdata[k*16 +: 16];
            end
        end
    end

    // Count write-back pulses.
    always @(posedge clk) begin
        if (wb_valid) wb_cnt <= wb_cnt + 1;
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [51:0] pk(input logic [12:0] i3, input logic [12:0] i2,
                                       input logic [12:0] i1, input logic [12:0] i0);
        return {i3, i2, i1, i0};
    endfunction

    function automatic logic [255:0] ramp(input logic [15:0] e0, input logic [15:0] mask);
        logic [255:0] v;
        for (int i = 0; i < 16; i++) v[i*16 +: 16] = (e0 + 16'(i)) & mask;
        return v;
    endfunction

    // Issue a load in the current cycle (cycle 0) and check cycles 1..7.
    task automatic run_load(input logic [15:0] base, input logic [3:0] vreg,
                            input logic [255:0] exp_data, input logic [51:0] exp_raddr0);
        req_valid = 1'b1; req_store = 1'b0; req_base = base; req_vreg = vreg;
        #1;
        chk("ld_ready_idle", req_ready, 1'b1);
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0;
            chk("ld_ren", bank_ren, (cyc <= 4) ? 4'hF : 4'h0);
            chk("ld_wb_valid", wb_valid, (cyc == 6));
            if (cyc == 1) chk("ld_raddr_beat0", bank_raddr, exp_raddr0);
            if (cyc >= 6) begin
                chk("ld_wb_vreg", wb_vreg, vreg);
                chk("ld_wb_data", wb_data, exp_data);
            end
        end
    endtask

    initial begin
        tbl[0] = '{16'h0000, 4'd3,  16'h0000, pk(13'd0, 13'd0, 13'd0, 13'd0)};
        tbl[1] = '{16'h0002, 4'd5,  16'h0001, pk(13'd0, 13'd0, 13'd0, 13'd1)};
        tbl[2] = '{16'h0003, 4'd7,  16'h0001, pk(13'd0, 13'd0, 13'd0, 13'd1)};
        tbl[3] = '{16'hFFFC, 4'd9,  16'h7FFE, pk(13'h1FFF, 13'h1FFF, 13'd0, 13'd0)};
        tbl[4] = '{16'h1234, 4'd12, 16'h091A, pk(13'h246, 13'h246, 13'h247, 13'h247)};

        clk = 1'b0; rst_n = 1'b1; mem_init = 1'b1; flush = 1'b0;
        req_valid = 1'b0; req_store = 1'b0; req_base = 16'h0; req_vreg = 4'd0;
        req_wdata = 256'h0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        mem_init = 1'b0;
        chk("rst_ready", req_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ren", bank_ren, 4'h0);
        chk("rst_wen", bank_wen, 4'h0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_vreg", wb_vreg, 4'd0);
        chk("rst_wb_data", wb_data, 256'h0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready_after", req_ready, 1'b1);
        @(negedge clk);

        for (int t = 0; t < 5; t++) begin
            run_load(tbl[t].base, tbl[t].vreg, ramp(tbl[t].e0, 16'h7FFF), tbl[t].raddr0);
        end

        // Store then reload the same vector.
        req_valid = 1'b1; req_store = 1'b1; req_base = 16'h0040; req_wdata = ramp(16'hA000, 16'hFFFF);
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0;
            chk("st_wen", bank_wen, (cyc <= 4) ? 4'hF : 4'h0);
            chk("st_ready", req_ready, (cyc == 5));
            if (cyc == 1) begin
                chk("st_waddr_beat0", bank_waddr, pk(13'd8, 13'd8, 13'd8, 13'd8));
                chk("st_wdata_beat0", bank_wdata, 64'hA003_A002_A001_A000);
            end
        end
        chk("st_mem_last", mem[3][11], 16'hA00F);
        run_load(16'h0040, 4'd4, ramp(16'hA000, 16'hFFFF), pk(13'd8, 13'd8, 13'd8, 13'd8));

        // Flush in cycle 3 of a load while another request is held pending.
        wb0 = wb_cnt;
        req_valid = 1'b1; req_store = 1'b0; req_base = 16'h0000; req_vreg = 4'd2;
        @(negedge clk);
        req_base = 16'h0002; req_vreg = 4'd6;
        chk("fl_ren_c1", bank_ren, 4'hF);
        @(negedge clk);
        chk("fl_ready_busy", req_ready, 1'b0);
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("fl_ren_flush", bank_ren, 4'h0);
        chk("fl_ready_flush", req_ready, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("fl_busy_c4", busy, 1'b0);
        chk("fl_ready_c4", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("fl_held_accepted", busy, 1'b1);
        for (int cyc = 6; cyc <= 10; cyc++) begin
            @(negedge clk);
            chk("fl_wb_valid", wb_valid, (cyc == 10));
            if (cyc == 10) begin
                chk("fl_wb_vreg", wb_vreg, 4'd6);
                chk("fl_wb_data", wb_data, ramp(16'h0001, 16'h7FFF));
            end
        end
        @(negedge clk);
        chk("fl_wb_count", wb_cnt - wb0, 1);

        // Flush in the write-back cycle suppresses the pulse.
        wb0 = wb_cnt;
        req_valid = 1'b1; req_store = 1'b0; req_base = 16'h0000; req_vreg = 4'd1;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flwb_wb_valid", wb_valid, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        chk("flwb_busy", busy, 1'b0);
        chk("flwb_wb_count", wb_cnt - wb0, 0);

        // Flush in IDLE blocks acceptance.
        flush = 1'b1; req_valid = 1'b1; req_store = 1'b0; req_base = 16'h0000;
        #1;
        chk("fli_ready", req_ready, 1'b0);
        @(negedge clk);
        chk("fli_busy", busy, 1'b0);
        flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);

        // Reset in cycle 2 of a store: only beat 0 lands.
        req_valid = 1'b1; req_store = 1'b1; req_base = 16'h0080; req_wdata = ramp(16'hB000, 16'hFFFF);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rs_wen_c1", bank_wen, 4'hF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rs_wen_rst", bank_wen, 4'h0);
        chk("rs_busy_rst", busy, 1'b0);
        chk("rs_ready_rst", req_ready, 1'b0);
        chk("rs_wb_data_rst", wb_data, 256'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rs_ready_after", req_ready, 1'b1);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("rs_beat0_written", mem[k][16], 16'hB000 + 16'(k));
            chk("rs_beat1_untouched", mem[k][17], 16'h0044 + 16'(k));
        end
        chk("rs_idle", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
